pkt_demux: RTL
==============

Name: pkt_demux

Overview:
- Registered 1-to-2 packet demultiplexer; the inverse of the team's 2:1 mux.
- Accepts a single valid/ready input stream and routes each whole packet to output 0 or output 1.
- The route is chosen by in_sel on the first beat of the packet and held until the beat marked in_last.
- Each output has a one-entry output register, giving 1-cycle latency and full throughput. Sits between a packet source and two downstream consumers.

Parameters:
WIDTH, 8, data bus width in bits
CNT_W, 8, width of per-output packet counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_data  input  WIDTH  input beat data
in_valid  input  1  input beat present
in_last  input  1  beat is final beat of packet
in_sel  input  1  route select (0 -> out0, 1 -> out1), sampled on first beat only
in_ready  output  1  block accepts beat this cycle
out0_data  output  WIDTH  output 0 data
out0_valid  output  1  output 0 beat present
out0_last  output  1  output 0 final beat
out0_ready  input  1  output 0 consumer accepts
out1_data  output  WIDTH  output 1 data
out1_valid  output  1  output 1 beat present
out1_last  output  1  output 1 final beat
out1_ready  input  1  output 1 consumer accepts
busy  output  1  mid-packet (state BUSY)
pkt_count0  output  CNT_W  packets delivered into out0 register
pkt_count1  output  CNT_W  packets delivered into out1 register

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high on rst.
- Reset (rst=1 at a clk edge): outN_valid=0, outN_data=0, outN_last=0, state=IDLE, route=0, busy=0, pkt_countN=0. in_ready=0 while rst=1.
- Target output: in IDLE, target = in_sel; in BUSY, target = latched route.
- in_ready (combinational) = !rst and (target outN_valid==0 or target outN_ready==1). A combinational path from outN_ready to in_ready is permitted.
- Transfer = in_valid & in_ready. On transfer, the target register loads in_data and in_last, and its valid is set at the next edge. Latency is 1 cycle.
- Output register drain: when outN_valid & outN_ready with no load in the same cycle, outN_valid clears at the next edge.
- Simultaneous load and drain: the new beat replaces the old one and outN_valid stays 1. Throughput is 1 beat/cycle.
- Hold: while outN_valid=1 and outN_ready=0, outN_data and outN_last are stable.
- The non-target output is unaffected by input activity and drains independently.
- FSM:
  - IDLE: on transfer, route <= in_sel. If in_last=0, go to BUSY; otherwise stay in IDLE (single-beat packet).
  - BUSY: in_sel is ignored. Each transfer goes to route. A transfer with in_last=1 returns to IDLE.
  - No transfer: state holds.
- busy = (state==BUSY).
- Counters: pkt_countN increments by 1 at the edge where a beat with in_last=1 is loaded into outN. Wraps from 2^CNT_W-1 to 0.
- in_valid=0: no state change, regardless of in_sel or in_last.
- Reset mid-packet: buffered beats are discarded, FSM returns to IDLE, counters clear. The next beat is treated as a first beat.
- Back-to-back packets to different outputs are allowed with no bubble: the beat after a last beat uses the new in_sel.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> in_ready=0, all outN_valid=0, pkt_count0=pkt_count1=0, busy=0.
- 3-beat packet, in_sel=1 on beat 1 only (beats 0xA1,0xA2,0xA3, last on 0xA3), out1_ready=1 -> out1 shows A1,A2,A3 on consecutive cycles, each 1 cycle after acceptance. out1_last only with A3. out0_valid stays 0. pkt_count1=1. busy high from after A1 until A3 is accepted.
- Back-pressure: out0_ready=0 during a 2-beat packet to out0 -> first beat held stable on out0, in_ready=0 for the second beat. Raising out0_ready -> second beat follows next cycle, no loss or duplication.
- Back-to-back single-beat packets alternating in_sel 0,1,0,1 (each in_last=1), both readies=1 -> in_ready constantly 1. pkt_count0=2, pkt_count1=2.
- Mid-packet in_sel toggle: in_sel flips 0->1 on beats 2..4 of a 4-beat packet started with sel=0 -> all 4 beats appear on out0.
- Reset mid-packet after 2 of 4 beats, then send a new 1-beat packet with in_sel=1 -> outputs cleared, new beat on out1, pkt_count1=1, pkt_count0=0. Counter wrap (CNT_W=2, 5 packets to out0) -> pkt_count0=1.

Source files
------------

// File: rtl/pkt_demux.sv
// Registered 1:2 packet demux: route picked by in_sel on a packet's first beat, held until in_last; 1-cycle latency.
// Backpressure: in_ready follows the target output register (free or draining this cycle), no bubbles between packets.
module pkt_demux #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count0,
  output logic [CNT_W-1:0] pkt_count1
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state;
  logic       route;
  logic       target;
  logic       target_free;
  logic       xfer;
  logic       load0;
  logic       load1;

  // The first beat of a packet steers by in_sel directly, so back-to-back packets need no bubble.
  assign target      = (state == BUSY) ? route : in_sel;
  assign target_free = target ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
  assign in_ready    = !rst && target_free;
  assign xfer        = in_valid && in_ready;
  assign load0       = xfer && !target;
  assign load1       = xfer && target;
  assign busy        = (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      route <= 1'b0;
    end else if (xfer) begin
      if (state == IDLE) begin
        route <= in_sel;
        state <= in_last ? IDLE : BUSY;
      end else if (in_last) begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
      out0_last  <= 1'b0;
      pkt_count0 <= '0;
    end else begin
      if (load0) begin
        out0_valid <= 1'b1;
        out0_data  <= in_data;
        out0_last  <= in_last;
        if (in_last) pkt_count0 <= pkt_count0 + CNT_W'(1);
      end else if (out0_ready) begin
        out0_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
      out1_last  <= 1'b0;
      pkt_count1 <= '0;
    end else begin
      if (load1) begin
        out1_valid <= 1'b1;
        out1_data  <= in_data;
        out1_last  <= in_last;
        if (in_last) pkt_count1 <= pkt_count1 + CNT_W'(1);
      end else if (out1_ready) begin
        out1_valid <= 1'b0;
      end
    end
  end

endmodule
